fifo_to_com: RTL and testbench

Transmit-side counterpart of the COM receive path. Pops bytes from the TX FIFO one at a time, serialises each as an 8N1 UART frame on tx, and runs a serial CRC8 over every byte sent. Sits between the TX FIFO and the board UART pin. It runs in the same clock domain as the rest of the design.

---
 rtl/fifo_to_com_pkg.sv | 36 +++
 rtl/fifo_to_com_uart_tx_core.sv | 66 ++++++
 rtl/fifo_to_com.sv | 124 ++++++++++++
 tb/tb_fifo_to_com.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_to_com_pkg.sv
// ============================================================================
// Module   : fifo_to_com_pkg
// Brief    : Shared types, frame constants and the serial CRC8 step for the
//            FIFO-to-UART transmit path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_to_com_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_CRC   = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    localparam logic [7:0] CRC_INIT   = 8'h00;
    localparam int         DATA_BITS  = 8;
    localparam int         FRAME_BITS = 10;

    // One MSB-first bit of the serial CRC8 register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic       data_bit,
                                             input logic [7:0] poly);
        logic fb;
        fb = crc_in[7] ^ data_bit;
        return {crc_in[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_to_com_uart_tx_core.sv
// ============================================================================
// Module   : fifo_to_com_uart_tx_core
// Brief    : 8N1 UART serialiser: baud counter, frame shift register, tx pin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_to_com_uart_tx_core
    import fifo_to_com_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       bit_done,
    output logic       frame_done,
    output logic [3:0] bit_index
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] frame;
    logic [15:0]           baud_cnt;
    logic [3:0]            bit_cnt;
    logic                  active;

    // The frame register refills with ones as it shifts, so tx rests high.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame    <= '1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
        end else if (start) begin
            frame    <= {1'b1, byte_in, 1'b0};
            baud_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b1;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                frame    <= {1'b1, frame[FRAME_BITS-1:1]};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    active  <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    assign tx         = frame[0];
    assign bit_done   = active && (baud_cnt == BAUD_LAST);
    assign frame_done = bit_done && (bit_cnt == LAST_BIT);
    assign bit_index  = bit_cnt;

endmodule

`default_nettype wire

// File: rtl/fifo_to_com.sv
// ============================================================================
// Module   : fifo_to_com
// Brief    : Pops TX FIFO bytes, sends each as an 8N1 frame and folds it into
//            a running CRC8. FIFO_TO_COM_CRC_APPEND_EN adds CRC-byte sending.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_to_com
    import fifo_to_com_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] CRC_POLY     = 8'h07
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data_in,
    output logic       fifo_re,
    input  logic       send_crc,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] crc,
    output logic [2:0] state
);

    state_t     state_q;
    state_t     next_state;
    logic [7:0] shift_reg;
    logic [2:0] crc_cnt;
    logic       append_mode;
    logic       append_go;
    logic       core_start;
    logic [7:0] core_byte;
    logic       bit_done;
    logic       frame_done;
    logic [3:0] bit_index;

`ifdef FIFO_TO_COM_CRC_APPEND_EN
    // FIFO data always wins over a CRC request.
    assign append_go = (state_q == ST_IDLE) && enable && fifo_empty && send_crc;
`else
    logic unused_send_crc;
    assign unused_send_crc = send_crc;
    assign append_go       = 1'b0;
`endif

    always_comb begin
        next_state = state_q;
        fifo_re    = 1'b0;
        core_start = 1'b0;
        core_byte  = fifo_data_in;
        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_re    = 1'b1;
                    next_state = ST_READ;
                end else if (append_go) begin
                    core_start = 1'b1;
                    core_byte  = crc;
                    next_state = ST_START;
                end
            end
            ST_READ: begin
                core_start = 1'b1;
                next_state = ST_START;
            end
            ST_START: if (bit_done) next_state = ST_DATA;
            ST_DATA:  if (bit_done && (bit_index == 4'(DATA_BITS))) next_state = ST_STOP;
            ST_STOP:  if (frame_done) next_state = append_mode ? ST_FIN : ST_CRC;
            ST_CRC:   if (crc_cnt == 3'd7) next_state = ST_FIN;
            ST_FIN:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_reg   <= '0;
            crc         <= CRC_INIT;
            crc_cnt     <= '0;
            append_mode <= 1'b0;
        end else begin
            state_q <= next_state;
            if (append_go) begin
                shift_reg   <= crc;
                crc         <= CRC_INIT;
                append_mode <= 1'b1;
            end
            if (state_q == ST_READ) begin
                shift_reg   <= fifo_data_in;
                append_mode <= 1'b0;
            end
            // CRC walks the latched byte MSB first, one bit per cycle.
            if (state_q == ST_CRC) begin
                crc     <= crc8_step(crc, shift_reg[3'd7 - crc_cnt], CRC_POLY);
                crc_cnt <= crc_cnt + 3'd1;
            end
        end
    end

    fifo_to_com_uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_core (
        .clk        (clk),
        .reset      (reset),
        .start      (core_start),
        .byte_in    (core_byte),
        .tx         (tx),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .bit_index  (bit_index)
    );

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_FIN);
    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_to_com.sv
// ============================================================================
// Module   : tb_fifo_to_com
// Brief    : Self-checking bench for fifo_to_com with a timeline-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_to_com;

    localparam int CPB = 4;
`ifdef FIFO_TO_COM_CRC_APPEND_EN
    localparam bit APPEND = 1'b1;
`else
    localparam bit APPEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data_in = 8'h00;
    logic       fifo_re;
    logic       send_crc = 1'b0;
    logic       tx, busy, done;
    logic [7:0] crc;
    logic [2:0] state;

    fifo_to_com #(.CLKS_PER_BIT(CPB), .CRC_POLY(8'h07)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_in(fifo_data_in), .fifo_re(fifo_re), .send_crc(send_crc),
        .tx(tx), .busy(busy), .done(done), .crc(crc), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // FIFO stand-in (fq) and the model's own view of the same pushes (mq)
    logic [7:0] fq[$];
    logic [7:0] mq[$];
    logic       re_seen = 1'b0;
    int         pops_dut = 0;

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        mq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (re_seen) begin
            pops_dut++;
            if (fq.size() > 0) fifo_data_in = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
    end

    // Model: pos counts cycles since the IDLE cycle that launched a byte.
    int         pos = -1;
    int         fstart = 2;
    int         fin_pos = 50;
    bit         app = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] crc_m = 8'h00;
    int         done_m = 0;
    logic [9:0] cap = '0;
    logic       e_re, e_tx, e_done;
    logic [2:0] e_state;
    int         idx;

    always @(negedge clk) begin
        re_seen = fifo_re;
        if (reset) begin
            pos   = -1;
            crc_m = 8'h00;
        end else begin
            e_re = 1'b0;
            if (pos < 0) begin
                if (enable && mq.size() > 0) begin
                    e_re = 1'b1;
                    cur = mq.pop_front();
                    pos = 0; fstart = 2; app = 1'b0;
                end else if (APPEND && enable && send_crc) begin
                    cur = crc_m;
                    pos = 0; fstart = 1; app = 1'b1;
                end
            end
            fin_pos = app ? fstart + 10*CPB : fstart + 10*CPB + 8;
            e_tx = 1'b1; e_done = 1'b0; e_state = 3'd0;
            if (pos > 0) begin
                if (pos < fstart) e_state = 3'd1;
                else if (pos < fstart + 10*CPB) begin
                    idx = (pos - fstart) / CPB;
                    e_state = (idx == 0) ? 3'd2 : (idx == 9) ? 3'd4 : 3'd3;
                    e_tx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : cur[idx-1];
                    if ((pos - fstart) % CPB == CPB/2) cap[idx] = tx;
                end else if (pos < fin_pos) e_state = 3'd5;
                else begin
                    e_state = 3'd6;
                    e_done = 1'b1;
                end
            end
            check("fifo_re", 32'(fifo_re), 32'(e_re));
            check("tx", 32'(tx), 32'(e_tx));
            check("state", 32'(state), 32'(e_state));
            check("busy", 32'(busy), 32'(e_state != 3'd0));
            check("done", 32'(done), 32'(e_done));
            if (pos < fstart + 10*CPB + 1 || pos >= fin_pos)
                check("crc", 32'(crc), 32'(crc_m));
            if (pos >= 0) begin
                if (app && pos == 0) crc_m = 8'h00;
                if (!app && pos == fin_pos - 1) crc_m = crc8_byte(crc_m, cur);
                if (pos == fin_pos) begin
                    pos = -1;
                    done_m++;
                end else pos++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int n, input string name);
        int t = 0;
        while (done_m < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_m < n) begin
            bad++;
            total++;
            $display("FAIL %s: timeout, done count %0d expected %0d", name, done_m, n);
        end
        tick();
    endtask

    task automatic wait_pos(input int p);
        int t = 0;
        while (pos != p && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (pos != p) begin
            bad++;
            total++;
            $display("FAIL wait_pos: timeout, pos %0d expected %0d", pos, p);
        end
    endtask

    string digits = "123456789";

    initial begin
        int base;
        do_reset(3);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_crc", 32'(crc), 32'h00);
        check("rst_state", 32'(state), 32'd0);
        repeat (5) tick();

        // single byte A5
        push(8'hA5);
        wait_done(1, "a5_done");
        check("a5_frame", 32'(cap), 32'h34A);
        check("a5_crc", 32'(crc), 32'h72);
        check("a5_pops", 32'(pops_dut), 32'd1);

        // 01 then FF from a cleared CRC
        do_reset(2);
        push(8'h01);
        wait_done(2, "b01_done");
        check("b01_crc", 32'(crc), 32'h07);
        push(8'hFF);
        wait_done(3, "bff_done");
        check("bff_crc", 32'(crc), 32'(crc8_byte(8'h07, 8'hFF)));

        // check string back-to-back
        do_reset(2);
        base = done_m;
        for (int i = 0; i < 9; i++) push(digits[i]);
        wait_done(base + 9, "str_done");
        check("str_count", 32'(done_m - base), 32'd9);
        check("str_crc", 32'(crc), 32'hF4);

        if (APPEND) begin
            send_crc = 1'b1;
            tick();
            send_crc = 1'b0;
            wait_done(base + 10, "app_done");
            check("app_frame", 32'(cap), 32'({1'b1, 8'hF4, 1'b0}));
            check("app_crc", 32'(crc), 32'h00);
        end

        // enable dropped during DATA of byte 1
        do_reset(2);
        base = done_m;
        pops_dut = 0;
        push(8'($urandom));
        push(8'($urandom));
        wait_pos(10);
        tick();
        enable = 1'b0;
        repeat (100) tick();
        check("en_done", 32'(done_m - base), 32'd1);
        check("en_pops", 32'(pops_dut), 32'd1);
        enable = 1'b1;
        wait_done(base + 2, "en_resume");
        check("en_pops2", 32'(pops_dut), 32'd2);

        // reset mid DATA
        push(8'($urandom));
        wait_pos(15);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_crc", 32'(crc), 32'h00);

        // randomized traffic
        repeat (1500) begin
            tick();
            if ($urandom_range(0, 19) == 0) push(8'($urandom));
            enable   = ($urandom_range(0, 9) != 0);
            send_crc = ($urandom_range(0, 29) == 0);
        end
        enable   = 1'b1;
        send_crc = 1'b0;
        begin
            int t = 0;
            while ((mq.size() > 0 || pos >= 0) && t < 20000) begin
                tick();
                t++;
            end
            check("drain", 32'(mq.size() > 0 || pos >= 0), 32'd0);
        end
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
